// File: rtl/mux_arb_nto1_pkg.sv
// Shared constants and helpers for the N-to-1 valid/ready arbitration mux.
package mux_arb_nto1_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n channels; at least 1 bit so a 1-of-2 select is representable.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_grant.sv
// Combinational one-hot grant: lowest-index requester at or after the start point, wrapping.
module rr_grant
  import mux_arb_nto1_pkg::*;
#(
  parameter int NUM   = 3,
  parameter int SEL_W = 2
) (
  input  logic [NUM-1:0]   req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             en_i,
  input  logic             mode_i,
  output logic [NUM-1:0]   gnt_o
);

  logic [2*NUM-1:0] dbl_req;
  logic [2*NUM-1:0] masked;
  logic [2*NUM-1:0] pick;
  logic [SEL_W-1:0] start;
  logic             found;

  assign start = mode_i ? ptr_i : '0;

  // Upper copy of the request vector lets the search wrap past channel NUM-1.
  always_comb begin
    dbl_req = {req_i, req_i};
    masked  = '0;
    pick    = '0;
    found   = 1'b0;
    for (int i = 0; i < 2*NUM; i++) begin
      masked[i] = dbl_req[i] && (i >= int'(start));
    end
    for (int i = 0; i < 2*NUM; i++) begin
      if (masked[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    gnt_o = en_i ? (pick[NUM-1:0] | pick[2*NUM-1:NUM]) : '0;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 valid/ready merge with fixed-priority or round-robin arbitration and a registered output.
module mux_arb_nto1
  import mux_arb_nto1_pkg::*;
#(
  parameter int  SIZE  = 32,
  parameter int  NUM   = 3,
  parameter int  MODE  = 1,
  localparam int SEL_W = clog2(NUM)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [NUM-1:0]      valid_i,
  output logic [NUM-1:0]      ready_o,
  output logic [SIZE-1:0]     data_o,
  output logic                valid_o,
  output logic [SEL_W-1:0]    sel_o,
  input  logic                ready_i
);

  logic             valid_q, valid_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [NUM-1:0]   gnt;
  logic [SEL_W-1:0] g_idx;
  logic [SIZE-1:0]  g_data;
  logic             xfer;
  logic             out_free;
  logic             rr_mode;

  assign rr_mode  = (MODE == MODE_RR);
  assign out_free = ~valid_q | ready_i;

  // Gating with rst_i keeps ready_o low for the whole time reset is held.
  rr_grant #(
    .NUM   (NUM),
    .SEL_W (SEL_W)
  ) u_grant (
    .req_i  (valid_i),
    .ptr_i  (ptr_q),
    .en_i   (out_free & rst_i),
    .mode_i (rr_mode),
    .gnt_o  (gnt)
  );

  assign ready_o = gnt;
  assign xfer    = |gnt;

  always_comb begin
    g_idx  = '0;
    g_data = '0;
    for (int k = 0; k < NUM; k++) begin
      if (gnt[k]) begin
        g_idx  = SEL_W'(k);
        g_data = data_i[k*SIZE +: SIZE];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = g_data;
      sel_d   = g_idx;
      if (rr_mode) begin
        ptr_d = (g_idx == SEL_W'(NUM-1)) ? '0 : g_idx + 1'b1;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Scoreboard bench: three instances (RR/3, fixed/3, RR/5) share stimulus and a behavioural arbiter model.
module tb_mux_arb_nto1;

  localparam int SIZE = 32;
  localparam int NMAX = 5;
  localparam int NI   = 3;

  typedef logic [SIZE+2:0] word_t;

  logic                 clk;
  logic                 rst_n;
  logic [NMAX*SIZE-1:0] data_in;
  logic [NMAX-1:0]      valid_in;
  logic                 ready_in;

  logic [2:0]      r0, r1;
  logic [4:0]      r2;
  logic [SIZE-1:0] d0, d1, d2;
  logic            v0, v1, v2;
  logic [1:0]      s0, s1;
  logic [2:0]      s2;

  logic [NMAX-1:0] dr [NI];
  logic [SIZE-1:0] dd [NI];
  logic            dv [NI];
  logic [2:0]      ds [NI];

  mux_arb_nto1 #(.SIZE(SIZE), .NUM(3), .MODE(1)) u_rr3 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data_in[3*SIZE-1:0]), .valid_i(valid_in[2:0]),
    .ready_o(r0), .data_o(d0), .valid_o(v0), .sel_o(s0), .ready_i(ready_in));

  mux_arb_nto1 #(.SIZE(SIZE), .NUM(3), .MODE(0)) u_fp3 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data_in[3*SIZE-1:0]), .valid_i(valid_in[2:0]),
    .ready_o(r1), .data_o(d1), .valid_o(v1), .sel_o(s1), .ready_i(ready_in));

  mux_arb_nto1 #(.SIZE(SIZE), .NUM(5), .MODE(1)) u_rr5 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data_in), .valid_i(valid_in),
    .ready_o(r2), .data_o(d2), .valid_o(v2), .sel_o(s2), .ready_i(ready_in));

  assign dr[0] = {2'b00, r0};
  assign dr[1] = {2'b00, r1};
  assign dr[2] = r2;
  assign dd[0] = d0;
  assign dd[1] = d1;
  assign dd[2] = d2;
  assign dv[0] = v0;
  assign dv[1] = v1;
  assign dv[2] = v2;
  assign ds[0] = {1'b0, s0};
  assign ds[1] = {1'b0, s1};
  assign ds[2] = s2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: words owed to the consumer, arbiter pointer, last word seen.
  word_t           sbq [NI][$];
  int              ptr_m [NI];
  logic [SIZE-1:0] last_d [NI];
  logic [2:0]      last_s [NI];

  int vectors;
  int miscompares;

  function automatic int num_of(input int i);
    return (i == 2) ? 5 : 3;
  endfunction

  function automatic bit rr_of(input int i);
    return (i != 1);
  endfunction

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic logic [NMAX*SIZE-1:0] rnd_data();
    logic [NMAX*SIZE-1:0] d;
    for (int k = 0; k < NMAX; k++) d[k*SIZE +: SIZE] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      sbq[i].delete();
      ptr_m[i]  = 0;
      last_d[i] = '0;
      last_s[i] = '0;
    end
  endtask

  // One clock cycle: drive at the falling edge, predict and check the grant 2 time units later.
  task automatic cycle(input logic [NMAX-1:0] v, input logic r, input logic rb,
                       input logic [NMAX*SIZE-1:0] d);
    logic [NMAX-1:0] exp_r;
    int              c;
    bit              done;
    @(negedge clk);
    valid_in = v;
    ready_in = r;
    data_in  = d;
    rst_n    = rb;
    if (!rb) model_reset();
    #2;
    for (int i = 0; i < NI; i++) begin
      exp_r = '0;
      done  = 1'b0;
      if (rb && sbq[i].size() == 0) begin
        for (int k = 0; k < num_of(i); k++) begin
          c = rr_of(i) ? (ptr_m[i] + k) % num_of(i) : k;
          if (!done && v[c]) begin
            done     = 1'b1;
            exp_r[c] = 1'b1;
            sbq[i].push_back({3'(c), d[c*SIZE +: SIZE]});
            if (rr_of(i)) ptr_m[i] = (c + 1) % num_of(i);
          end
        end
      end
      check("ready_o", i, 64'(dr[i]), 64'(exp_r));
    end
  endtask

  // Monitor: compares the presented word against the scoreboard head, pops on consume.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        check("valid_o", i, 64'(dv[i]), 64'(sbq[i].size() != 0));
        if (sbq[i].size() != 0) begin
          w = sbq[i][0];
          check("data_o", i, 64'(dd[i]), 64'(w[SIZE-1:0]));
          check("sel_o", i, 64'(ds[i]), 64'(w[SIZE+2:SIZE]));
          if (ready_in) begin
            void'(sbq[i].pop_front());
            last_d[i] = w[SIZE-1:0];
            last_s[i] = w[SIZE+2:SIZE];
          end
        end else begin
          check("data_o_hold", i, 64'(dd[i]), 64'(last_d[i]));
          check("sel_o_hold", i, 64'(ds[i]), 64'(last_s[i]));
        end
      end
    end
  end

  initial begin
    logic [NMAX*SIZE-1:0] tmp;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    valid_in    = '0;
    ready_in    = 1'b0;
    data_in     = '0;
    model_reset();

    cycle(5'b11111, 1'b1, 1'b0, rnd_data());
    cycle(5'b00000, 1'b1, 1'b0, rnd_data());
    cycle(5'b00000, 1'b1, 1'b1, rnd_data());

    tmp = '0;
    tmp[1*SIZE +: SIZE] = 32'h11;
    tmp[2*SIZE +: SIZE] = 32'h22;
    repeat (4) cycle(5'b00110, 1'b1, 1'b1, tmp);

    repeat (8) cycle(5'b11111, 1'b1, 1'b1, rnd_data());

    for (int k = 0; k < NMAX; k++) tmp[k*SIZE +: SIZE] = 32'hA5;
    cycle(5'b11111, 1'b1, 1'b1, tmp);
    repeat (4) cycle(5'b11111, 1'b0, 1'b1, rnd_data());
    repeat (3) cycle(5'b11111, 1'b1, 1'b1, rnd_data());

    cycle(5'b10000, 1'b1, 1'b1, rnd_data());
    repeat (4) cycle(5'b01010, 1'b1, 1'b1, rnd_data());

    cycle(5'b00100, 1'b1, 1'b1, rnd_data());
    repeat (3) cycle(5'b00000, 1'b1, 1'b1, rnd_data());

    cycle(5'b11111, 1'b1, 1'b1, rnd_data());
    repeat (2) cycle(5'b11111, 1'b0, 1'b1, rnd_data());
    cycle(5'b11111, 1'b0, 1'b0, rnd_data());
    cycle(5'b11111, 1'b0, 1'b1, rnd_data());
    cycle(5'b00000, 1'b1, 1'b1, rnd_data());

    repeat (600) begin
      cycle(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 1'b1, rnd_data());
    end
    repeat (2) cycle(5'b00000, 1'b1, 1'b1, rnd_data());

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised successor to the pipeline's fixed 3:1 select mux.
- Merges NUM producer channels onto one registered output, using valid/ready handshakes on every channel.
- Arbitration is fixed-priority or round-robin, chosen by parameter.
- Used where several pipeline sources contend for one shared resource, e.g. write-back port, memory request path, or forwarding bus.

Parameters:
- SIZE, 32, data width per channel in bits (≥1).
- NUM, 3, number of input channels (≥2).
- MODE, 1, arbitration policy: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- SEL_W, clog2(NUM), width of the channel index. Derived; never overridden.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, reset. Asynchronous, active-low.
- data_i, input, NUM*SIZE, packed channel data; channel k occupies bits [k*SIZE +: SIZE].
- valid_i, input, NUM, per-channel request.
- ready_o, output, NUM, per-channel accept; at most one bit set per cycle.
- data_o, output, SIZE, registered merged data.
- valid_o, output, 1, data_o holds an unconsumed word.
- sel_o, output, SEL_W, index of the channel that supplied data_o.
- ready_i, input, 1, downstream accept.

Behaviour:
- Reset (rst_i low, asynchronous): valid_o=0, data_o=0, sel_o=0, round-robin pointer=0.
  - Any held word is discarded.
  - ready_o is 0 combinationally while reset is asserted.
- Output stage: one-entry register. It is free when valid_o=0 or (valid_o & ready_i).
- Grant:
  - Computed combinationally from valid_i and the pointer, only when the output stage is free; otherwise ready_o is all zero.
  - ready_o[g]=1 only for the granted channel g. A transfer on channel g is valid_i[g] & ready_o[g].
  - ready_o never depends on valid_i of the same channel, apart from the arbitration among requesters.
- Transfer: on the clock edge after a grant, data_o ← channel g data, sel_o ← g, valid_o ← 1.
  - Latency is 1 cycle from accept to valid_o.
- Consume without new grant: if valid_o & ready_i and no channel requests, valid_o ← 0. data_o and sel_o hold their values.
- Stall: while valid_o & ~ready_i, data_o and sel_o are stable and all ready_o are 0.
- Simultaneous consume and grant: a new word loads in the same cycle. Full throughput is one word per cycle.
- Fixed priority (MODE=0): the lowest-index requesting channel wins. Pointer unused.
- Round-robin (MODE=1):
  - Search starts at the pointer index and wraps modulo NUM.
  - After a transfer from channel g, pointer ← (g+1) mod NUM. Wrap: g=NUM-1 gives pointer 0.
  - The pointer changes only on an actual transfer.
- Boundary conditions:
  - No requests: no grant, no state change except clearing valid_o on consume.
  - A channel dropping valid_i before grant is legal; the request is simply not served.
  - Unused index values (NUM not a power of 2) never appear on sel_o.
  - Every output is fully assigned in every path: no latches, no undefined select.

Decomposition:
- Shared package: MODE_FIXED=0, MODE_RR=1, and the clog2 function used for SEL_W.
- One sub-module, rr_grant: purely combinational.
  - Inputs: NUM-bit request vector, pointer, enable, mode.
  - Output: one-hot NUM-bit grant.
  - Implemented as a double-width masked priority search.
- The top level holds the output register, the pointer and the data select.

Test Plan:
- Reset mid-stall: hold valid_o=1, ready_i=0; pulse rst_i low between edges → valid_o=0, data_o=0, sel_o=0 immediately, ready_o=0 during reset.
- Fixed priority (MODE=0, NUM=3, SIZE=32): valid_i=3'b110, ready_i=1, data ch1=0x11, ch2=0x22 → ready_o=3'b010; next cycle data_o=0x11, sel_o=1. Ch1 keeps winning while it requests.
- Round-robin fairness (MODE=1, NUM=3): all three valid continuously, ready_i=1 → sel_o sequence 0,1,2,0,1,2 on consecutive cycles, valid_o held at 1 (back-to-back).
- Backpressure (MODE=1): ready_i=0 for 4 cycles with valid_o=1, data_o=0xA5 → data_o and sel_o stable, ready_o=0, pointer unchanged. When ready_i=1 the next grant loads in the same cycle.
- Wrap and sparse requests (NUM=5, MODE=1): after a grant to channel 4, only ch1 and ch3 requesting → ch1 granted, then ch3, then ch1.
- Idle drain: single word from ch2, then no requests, ready_i=1 → valid_o=0 after one cycle, data_o retains the last value, sel_o=2.
